// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared ISA field positions, opcode/aluop constants and FSM states
// for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RD_HI = 26;
    localparam int RD_LO = 22;
    localparam int RS_HI = 21;
    localparam int RS_LO = 17;
    localparam int RT_HI = 16;
    localparam int RT_LO = 12;
    localparam int AL_HI = 6;
    localparam int AL_LO = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_decode.sv
// Combinational hazard detection from the F/D and D/X instructions.
// Ports: fd_ir, dx_ir in; w_load_use, w_is_mul, w_is_div out.
module pipe_hazard_ctrl_hazard_decode
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    output logic        w_load_use,
    output logic        w_is_mul,
    output logic        w_is_div
);

    logic [4:0] w_dx_op;
    logic [4:0] w_dx_rd;
    logic [4:0] w_dx_alu;
    logic [4:0] w_fd_op;
    logic [4:0] w_fd_rs;
    logic [4:0] w_fd_rt;
    logic       w_rs_hit;
    logic       w_rt_hit;

    // Bits no hazard check looks at.
    logic [33:0] w_unused_bits;
    assign w_unused_bits = {fd_ir[26:22], fd_ir[11:0],
                            dx_ir[21:7], dx_ir[1:0]};

    assign w_dx_op  = dx_ir[OP_HI:OP_LO];
    assign w_dx_rd  = dx_ir[RD_HI:RD_LO];
    assign w_dx_alu = dx_ir[AL_HI:AL_LO];
    assign w_fd_op  = fd_ir[OP_HI:OP_LO];
    assign w_fd_rs  = fd_ir[RS_HI:RS_LO];
    assign w_fd_rt  = fd_ir[RT_HI:RT_LO];

    // rs is a source for every format; rt is only read by R-type.
    assign w_rs_hit = (w_dx_rd == w_fd_rs);
    assign w_rt_hit = (w_fd_op == OP_RTYPE) && (w_dx_rd == w_fd_rt);

    assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0)
                      && (w_rs_hit || w_rt_hit);

    assign w_is_mul = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_MUL);
    assign w_is_div = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_DIV);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: load-use stalls, branch flushes, multdiv
// busy stalls with timeout. Inputs: clk (falling edge), clr (async
// active-low), fd_ir, dx_ir, branch_taken, md_rdy. Outputs: latch
// enables, flushes, md_mult/md_div/md_sel, md_err, stall_cnt.
// Optional STALL_CNT_EN macro enables the saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_rdy,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    output logic        md_mult,
    output logic        md_div,
    output logic        md_sel,
    output logic        md_err,
    output logic [31:0] stall_cnt
);

    localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(MD_TIMEOUT - 1);

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_err;
    logic          r_skip;
    logic          w_load_use;
    logic          w_is_mul;
    logic          w_is_div;
    logic          w_md_start;

    pipe_hazard_ctrl_hazard_decode u_dec (
        .fd_ir      (fd_ir),
        .dx_ir      (dx_ir),
        .w_load_use (w_load_use),
        .w_is_mul   (w_is_mul),
        .w_is_div   (w_is_div)
    );

    // r_skip marks the cycle after a timeout: the abandoned mul/div still
    // sits in D/X and must advance as a nop instead of restarting.
    assign w_md_start = !r_skip && (w_is_mul || w_is_div);

    always_comb begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        dx_we    = 1'b0;
        xm_we    = 1'b0;
        mw_we    = 1'b0;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        md_mult  = 1'b0;
        md_div   = 1'b0;
        md_sel   = 1'b0;
        if (clr) begin
            unique case (r_state)
                ST_RUN: begin
                    pc_we    = 1'b1;
                    fd_we    = 1'b1;
                    dx_we    = 1'b1;
                    xm_we    = 1'b1;
                    mw_we    = 1'b1;
                    xm_flush = r_skip;
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (w_md_start) begin
                        md_mult  = w_is_mul;
                        md_div   = w_is_div;
                        pc_we    = 1'b0;
                        fd_we    = 1'b0;
                        dx_we    = 1'b0;
                        xm_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_we    = 1'b0;
                        fd_we    = 1'b0;
                        dx_flush = 1'b1;
                    end
                end
                ST_BUSY: begin
                    xm_we    = 1'b1;
                    mw_we    = 1'b1;
                    xm_flush = 1'b1;
                end
                ST_DONE: begin
                    pc_we  = 1'b1;
                    fd_we  = 1'b1;
                    dx_we  = 1'b1;
                    xm_we  = 1'b1;
                    mw_we  = 1'b1;
                    md_sel = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_RUN;
            r_timer <= '0;
            r_err   <= 1'b0;
            r_skip  <= 1'b0;
        end else begin
            r_skip <= 1'b0;
            unique case (r_state)
                ST_RUN: begin
                    if (!branch_taken && w_md_start) begin
                        r_state <= ST_BUSY;
                        r_timer <= '0;
                    end
                end
                ST_BUSY: begin
                    r_timer <= r_timer + 1'b1;
                    if (md_rdy) begin
                        r_state <= ST_DONE;
                    end else if (r_timer == TMAX) begin
                        r_err   <= 1'b1;
                        r_skip  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign md_err = r_err;

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_stall_cnt <= '0;
        end else if (!pc_we && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// Inputs change just after the falling edge; outputs sampled on the rising edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        branch_taken;
    logic        md_rdy;
    logic        pc_we, fd_we, dx_we, xm_we, mw_we;
    logic        fd_flush, dx_flush, xm_flush;
    logic        md_mult, md_div, md_sel, md_err;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int stall_m = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_TIMEOUT(40)) dut (
        .clk          (clk),
        .clr          (clr),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_rdy       (md_rdy),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .xm_we        (xm_we),
        .mw_we        (mw_we),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_flush     (xm_flush),
        .md_mult      (md_mult),
        .md_div       (md_div),
        .md_sel       (md_sel),
        .md_err       (md_err),
        .stall_cnt    (stall_cnt)
    );

    // {pc,fd,dx,xm,mw _we, fd,dx,xm _flush, mult, div, sel}
    logic [10:0] ctrl;
    assign ctrl = {pc_we, fd_we, dx_we, xm_we, mw_we,
                   fd_flush, dx_flush, xm_flush,
                   md_mult, md_div, md_sel};

    localparam logic [10:0] V_ZERO = 11'b00000_000_000;
    localparam logic [10:0] V_RUN  = 11'b11111_000_000;
    localparam logic [10:0] V_LU   = 11'b00111_010_000;
    localparam logic [10:0] V_BR   = 11'b11111_110_000;
    localparam logic [10:0] V_MUL  = 11'b00011_001_100;
    localparam logic [10:0] V_DIV  = 11'b00011_001_010;
    localparam logic [10:0] V_BUSY = 11'b00011_001_000;
    localparam logic [10:0] V_DONE = 11'b11111_000_001;
    localparam logic [10:0] V_SKIP = 11'b11111_001_000;

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, rs);
        return {5'b01000, rd, rs, 17'd0};
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef STALL_CNT_EN
        return 32'(stall_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx,
                        input logic br, input logic rdy,
                        input logic [10:0] ev, input string tag);
        fd_ir = fd;
        dx_ir = dx;
        branch_taken = br;
        md_rdy = rdy;
        @(posedge clk);
        chk(tag, {21'd0, ctrl}, {21'd0, ev});
        if (!ev[10]) stall_m++;
        @(negedge clk);
        #1;
    endtask

    logic [31:0] NOP, ADD, ADD_RT, LW5, LW0, ADD0, MUL, DIV;

    initial begin
        NOP    = 32'd0;
        ADD    = rtype(5'd1, 5'd5, 5'd2, 5'b00000);
        ADD_RT = rtype(5'd1, 5'd2, 5'd5, 5'b00000);
        ADD0   = rtype(5'd1, 5'd0, 5'd2, 5'b00000);
        LW5    = lw(5'd5, 5'd3);
        LW0    = lw(5'd0, 5'd3);
        MUL    = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        DIV    = rtype(5'd4, 5'd1, 5'd2, 5'b00111);

        // reset with hazardous inputs present
        clr = 1'b0;
        fd_ir = ADD;
        dx_ir = LW5;
        branch_taken = 1'b1;
        md_rdy = 1'b1;
        @(posedge clk);
        chk("reset_ctrl", {21'd0, ctrl}, {21'd0, V_ZERO});
        chk("reset_err", {31'd0, md_err}, 32'd0);
        chk("reset_stall", stall_cnt, 32'd0);
        @(negedge clk);
        #1;
        clr = 1'b1;

        step(ADD, NOP, 1'b0, 1'b0, V_RUN, "run_idle");
        step(ADD, NOP, 1'b0, 1'b1, V_RUN, "rdy_outside_busy");

        // 1: load-use on rs, then resumes
        step(ADD, LW5, 1'b0, 1'b0, V_LU, "lu_rs");
        step(ADD, NOP, 1'b0, 1'b0, V_RUN, "lu_release");
        step(ADD_RT, LW5, 1'b0, 1'b0, V_LU, "lu_rt");
        step(ADD_RT, NOP, 1'b0, 1'b0, V_RUN, "lu_rt_release");
        // 2: rd = r0 never stalls
        step(ADD0, LW0, 1'b0, 1'b0, V_RUN, "lu_r0");
        // 3: branch wins over load-use
        step(ADD, LW5, 1'b1, 1'b0, V_BR, "lu_branch");
        step(NOP, NOP, 1'b0, 1'b0, V_RUN, "post_branch");
        chk("stall_after_lu", stall_cnt, exp_stall());

        // 4: mul with result after 32 busy cycles
        step(ADD, MUL, 1'b0, 1'b0, V_MUL, "mul_start");
        for (int k = 0; k < 32; k++)
            step(ADD, MUL, (k == 5), (k == 31), V_BUSY, "mul_busy");
        step(ADD, MUL, 1'b0, 1'b1, V_DONE, "mul_done");
        step(ADD, NOP, 1'b0, 1'b0, V_RUN, "mul_resume");
        chk("mul_err", {31'd0, md_err}, 32'd0);
        chk("stall_after_mul", stall_cnt, exp_stall());

        // 5: div that never completes
        step(ADD, DIV, 1'b0, 1'b0, V_DIV, "div_start");
        for (int k = 0; k < 40; k++) begin
            step(ADD, DIV, 1'b0, 1'b0, V_BUSY, "div_busy");
            if (k == 38) chk("div_err_early", {31'd0, md_err}, 32'd0);
        end
        chk("div_err_set", {31'd0, md_err}, 32'd1);
        step(ADD, DIV, 1'b0, 1'b0, V_SKIP, "div_retire_nop");
        step(ADD, NOP, 1'b0, 1'b0, V_RUN, "div_resume");
        step(ADD, LW5, 1'b0, 1'b0, V_LU, "lu_after_err");
        step(ADD, NOP, 1'b0, 1'b0, V_RUN, "run_after_err");
        chk("div_err_sticky", {31'd0, md_err}, 32'd1);
        chk("stall_after_div", stall_cnt, exp_stall());

        // 6: clr mid-busy
        step(ADD, MUL, 1'b0, 1'b0, V_MUL, "mul2_start");
        step(ADD, MUL, 1'b0, 1'b0, V_BUSY, "mul2_busy");
        step(ADD, MUL, 1'b0, 1'b0, V_BUSY, "mul2_busy");
        clr = 1'b0;
        stall_m = 0;
        @(posedge clk);
        chk("clr_ctrl", {21'd0, ctrl}, {21'd0, V_ZERO});
        chk("clr_err", {31'd0, md_err}, 32'd0);
        chk("clr_stall", stall_cnt, 32'd0);
        @(negedge clk);
        #1;
        dx_ir = NOP;
        @(negedge clk);
        #1;
        clr = 1'b1;
        step(ADD, NOP, 1'b0, 1'b1, V_RUN, "clr_resume");
        chk("clr_stall_zero", stall_cnt, exp_stall());
        step(ADD, LW5, 1'b0, 1'b0, V_LU, "clr_lu");
        step(ADD, NOP, 1'b0, 1'b0, V_RUN, "clr_lu_release");
        chk("clr_stall_count", stall_cnt, exp_stall());
        chk("clr_err_after", {31'd0, md_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
